// File: rtl/uart_word_tx.sv
// Serialises a captured 32-bit data-memory word onto one TX line as four
// back-to-back 8N1 frames, least-significant byte first.

module uart_word_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enableUart,
    input  logic [31:0] dataUart,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } TxState;

    TxState           state;
    TxState           stateNext;
    logic             enPrev;
    logic [31:0]      shift;
    logic [31:0]      shiftNext;
    logic [CNT_W-1:0] bitCnt;
    logic [CNT_W-1:0] bitCntNext;
    logic [2:0]       bitIdx;
    logic [2:0]       bitIdxNext;
    logic [1:0]       byteIdx;
    logic [1:0]       byteIdxNext;
    logic             txNext;
    logic             busyNext;
    logic             doneNext;

    logic             startReq;
    logic             bitEnd;
    logic [2:0]       nextBitIdx;

    assign startReq   = enableUart && !enPrev;
    assign bitEnd     = (bitCnt == LAST_CNT);
    assign nextBitIdx = bitIdx + 3'd1;

    // tx, busy and done are all registered so the line never glitches; the
    // next-state logic therefore computes the value tx takes for the coming bit.
    always_comb begin
        stateNext   = state;
        shiftNext   = shift;
        bitIdxNext  = bitIdx;
        byteIdxNext = byteIdx;
        txNext      = tx;
        busyNext    = busy;
        doneNext    = 1'b0;
        bitCntNext  = bitEnd ? '0 : bitCnt + CNT_W'(1);

        case (state)
            IDLE: begin
                txNext     = 1'b1;
                busyNext   = 1'b0;
                bitCntNext = '0;
                if (startReq) begin
                    shiftNext   = dataUart;
                    byteIdxNext = 2'd0;
                    bitIdxNext  = 3'd0;
                    txNext      = 1'b0;
                    busyNext    = 1'b1;
                    stateNext   = START;
                end
            end

            START: begin
                if (bitEnd) begin
                    stateNext  = DATA;
                    bitIdxNext = 3'd0;
                    txNext     = shift[{byteIdx, 3'd0}];
                end
            end

            DATA: begin
                if (bitEnd) begin
                    if (bitIdx == 3'd7) begin
                        stateNext = STOP;
                        txNext    = 1'b1;
                    end else begin
                        bitIdxNext = nextBitIdx;
                        txNext     = shift[{byteIdx, nextBitIdx}];
                    end
                end
            end

            STOP: begin
                if (bitEnd) begin
                    if (byteIdx == 2'd3) begin
                        stateNext = IDLE;
                        doneNext  = 1'b1;
                        busyNext  = 1'b0;
                        txNext    = 1'b1;
                    end else begin
                        byteIdxNext = byteIdx + 2'd1;
                        stateNext   = START;
                        txNext      = 1'b0;
                    end
                end
            end

            default: begin
                stateNext = IDLE;
                txNext    = 1'b1;
                busyNext  = 1'b0;
            end
        endcase
    end

    // Reset abandons any partial frame; the line is back high one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            enPrev  <= 1'b0;
            shift   <= '0;
            bitCnt  <= '0;
            bitIdx  <= 3'd0;
            byteIdx <= 2'd0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= stateNext;
            enPrev  <= enableUart;
            shift   <= shiftNext;
            bitCnt  <= bitCntNext;
            bitIdx  <= bitIdxNext;
            byteIdx <= byteIdxNext;
            tx      <= txNext;
            busy    <= busyNext;
            done    <= doneNext;
        end
    end

endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Serial transmitter that consumes the 32-bit word presented by the data memory on its UART read port. It sits directly downstream of the data memory. When the memory's UART enable rises, it captures the word and sends it on a single TX line as four 8N1 UART frames, least-significant byte first. It reports busy and done status back to the processor side.

## Interface
- CLKS_PER_BIT, default 868: clock cycles per serial bit (100 MHz / 115200 baud); legal range ≥ 2.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- enableUart  input  1  transmit request from the data memory; only its rising edge is acted on.
- dataUart  input  32  word from the data memory UART port; sampled only on the accepted rising edge of enableUart.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a word is being transmitted.
- done  output  1  one-cycle pulse when the last stop bit of a word completes.

## Operation
- Registers:
  - enPrev: enableUart delayed one cycle.
  - shift[31:0]: captured word.
  - bitCnt: 0..CLKS_PER_BIT-1; width $clog2(CLKS_PER_BIT).
  - bitIdx: 0..7.
  - byteIdx: 0..3.
- Start condition: enableUart=1, enPrev=0 and state IDLE.
  - A held-high enableUart therefore sends exactly one word.
  - A rising edge while busy is ignored and is not queued.
- States:
  - IDLE: tx=1, busy=0. On start condition: shift<=dataUart, byteIdx<=0, bitCnt<=0, tx<=0, state<=START.
  - START: tx=0 for CLKS_PER_BIT cycles, then state<=DATA, bitIdx<=0.
  - DATA: tx=shift[8*byteIdx+bitIdx], LSB first, each bit held CLKS_PER_BIT cycles. After bitIdx=7 completes, state<=STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then:
    - if byteIdx=3: state<=IDLE, done<=1 for one cycle, busy<=0;
    - else: byteIdx<=byteIdx+1, state<=START (no idle gap between bytes).
- bitCnt resets to 0 on every bit boundary. It never exceeds CLKS_PER_BIT-1.
- tx is driven from a register, so it has no combinational glitches.
- dataUart changing mid-word has no effect; shift holds the captured value.
- Reset (any state, including mid-frame):
  - outputs: tx=1, busy=0, done=0;
  - internal: state=IDLE, enPrev=0, all counters 0.
  - The partial frame is abandoned; the line returns high on the next cycle.
- Since enPrev resets to 0, if enableUart is already high on the first cycle after reset, the start condition fires.

## Timing
- Accepted edge sampled at clock edge k:
  - tx falls and busy rises at edge k (registered outputs, visible after edge k).
- Byte n (n=0..3) start bit begins at edge k + 10·n·CLKS_PER_BIT.
- Data bit b of byte n is on tx during cycles [k + (10n+1+b)·CLKS_PER_BIT, k + (10n+2+b)·CLKS_PER_BIT).
- Stop bit of byte n occupies the following CLKS_PER_BIT cycles.
- At edge k + 40·CLKS_PER_BIT:
  - done=1 for exactly one cycle;
  - busy=0;
  - tx remains 1.
- The earliest next accepted start is the edge after done. It requires enableUart to have been low for at least one sampled cycle.
- Total word latency: 40·CLKS_PER_BIT cycles. No backpressure; the line is never stalled.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset: hold rst 3 cycles -> tx=1, busy=0, done=0. Release with enableUart=0 -> still idle.
- Single word: dataUart=32'hAAF00FAA, then pulse enableUart -> tx carries bytes AA, 0F, F0, AA, each as 0 + LSB-first bits + 1, every bit 4 cycles wide. done pulses once at 160 cycles; busy high for exactly 160 cycles.
- Held enable: enableUart held high 1000 cycles with dataUart=1 -> exactly one word sent (bytes 01, 00, 00, 00), then tx stays 1.
- Retrigger ignored: second enableUart rising edge at cycle 50 of a word, with dataUart changed to 32'h12345678 -> the original word completes unchanged and no second word follows.
- Reset mid-frame: assert rst during DATA of byte 1 -> tx=1 and busy=0 on the next cycle, no done pulse. A subsequent enable sends a full fresh word.
- Back-to-back: drop enableUart for 1 cycle after done, raise it with dataUart=32'h00000055 -> the new start bit begins on that edge and the first byte reads 55.
